// File: rtl/rr_grant_if.sv
// Grant bus between the requesters (master side) and the round-robin arbiter (slave side).
interface rr_grant_if;
  logic       en;
  logic [3:0] req;
  logic [3:0] gnt;
  logic [1:0] gnt_idx;
  logic       gnt_valid;
  logic       preempt;

  modport master (
    output en, req,
    input  gnt, gnt_idx, gnt_valid, preempt
  );

  modport slave (
    input  en, req,
    output gnt, gnt_idx, gnt_valid, preempt
  );
endinterface

// File: rtl/rr_grant_ctrl.sv
// Four-way round-robin arbiter with registered one-hot grant, binary index and
// an optional hold-time limit that pre-empts the owner when others are waiting.
module rr_grant_ctrl #(
  parameter int unsigned MAX_HOLD = 8,
  parameter int unsigned CNT_W    = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  rr_grant_if.slave  bus
);

  localparam int unsigned N_REQ = 4;
  localparam int unsigned IDX_W = 2;
  localparam bit          PREEMPT_EN = (MAX_HOLD != 0);
  localparam logic [CNT_W-1:0] HOLD_LAST = (MAX_HOLD == 0) ? '0 : CNT_W'(MAX_HOLD - 1);

  typedef enum logic {IDLE, GRANT} state_e;

  state_e             state_q, state_d;
  logic [IDX_W-1:0]   ptr_q, ptr_d;
  logic [CNT_W-1:0]   hold_cnt_q, hold_cnt_d;
  logic [N_REQ-1:0]   gnt_q, gnt_d;
  logic [IDX_W-1:0]   gnt_idx_q, gnt_idx_d;
  logic               gnt_valid_q, gnt_valid_d;
  logic               preempt_q, preempt_d;

  logic [IDX_W-1:0]   pick_c;
  logic [IDX_W-1:0]   cand_c;
  logic               found_c;
  logic               others_wait_c;

  // First requester at or after ptr in circular order.
  always_comb begin
    pick_c  = '0;
    cand_c  = '0;
    found_c = 1'b0;
    for (int i = 0; i < N_REQ; i++) begin
      cand_c = ptr_q + IDX_W'(i);
      if (!found_c && bus.req[cand_c]) begin
        pick_c  = cand_c;
        found_c = 1'b1;
      end
    end
  end

  assign others_wait_c = |(bus.req & ~gnt_q);

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    hold_cnt_d  = hold_cnt_q;
    gnt_d       = gnt_q;
    gnt_idx_d   = gnt_idx_q;
    gnt_valid_d = gnt_valid_q;
    preempt_d   = 1'b0;

    case (state_q)
      IDLE: begin
        gnt_d       = '0;
        gnt_idx_d   = '0;
        gnt_valid_d = 1'b0;
        if (bus.en && found_c) begin
          state_d     = GRANT;
          gnt_d       = N_REQ'(1) << pick_c;
          gnt_idx_d   = pick_c;
          gnt_valid_d = 1'b1;
          hold_cnt_d  = '0;
        end
      end
      GRANT: begin
        // Release and pre-emption both pass priority to the next requester.
        if (!bus.req[gnt_idx_q] ||
            (PREEMPT_EN && (hold_cnt_q == HOLD_LAST) && others_wait_c)) begin
          state_d     = IDLE;
          gnt_d       = '0;
          gnt_idx_d   = '0;
          gnt_valid_d = 1'b0;
          ptr_d       = gnt_idx_q + IDX_W'(1);
          preempt_d   = bus.req[gnt_idx_q];
        end else if (hold_cnt_q != HOLD_LAST) begin
          hold_cnt_d = hold_cnt_q + CNT_W'(1);
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      ptr_q       <= '0;
      hold_cnt_q  <= '0;
      gnt_q       <= '0;
      gnt_idx_q   <= '0;
      gnt_valid_q <= 1'b0;
      preempt_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      hold_cnt_q  <= hold_cnt_d;
      gnt_q       <= gnt_d;
      gnt_idx_q   <= gnt_idx_d;
      gnt_valid_q <= gnt_valid_d;
      preempt_q   <= preempt_d;
    end
  end

  assign bus.gnt       = gnt_q;
  assign bus.gnt_idx   = gnt_idx_q;
  assign bus.gnt_valid = gnt_valid_q;
  assign bus.preempt   = preempt_q;

endmodule
